// File: rtl/game_pkg.sv
// Shared game constants, HP arbiter FSM encoding and global game-state codes.
package game_pkg;

  localparam int GAME_HP_W         = 10;
  localparam int GAME_HP_MAX       = 511;
  localparam int GAME_PLAY_STATE   = 1;
  localparam int GAME_TICK_DIV     = 350000;
  localparam int GAME_INVULN_TICKS = 60;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_INVULN = 2'd2,
    ST_DEAD   = 2'd3
  } hp_fsm_e;

  // Values of the global state[3:0] bus shared by the sprite blocks.
  localparam logic [3:0] GS_TITLE    = 4'd0;
  localparam logic [3:0] GS_PLAY     = 4'd1;
  localparam logic [3:0] GS_GAMEOVER = 4'd2;
  localparam logic [3:0] GS_PAUSE    = 4'd3;

endpackage

// File: rtl/hp_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
module rr_arbiter
  import game_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]                              i_req,
  input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]                              o_grant,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_idx,
  output logic                                            o_valid
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] w_rot_idx [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [PW:0] w_sum;
    assign w_sum = {1'b0, i_ptr} + (PW+1)'(gi);
    assign w_rot_idx[gi] = (w_sum >= (PW+1)'(NUM_REQ)) ? PW'(w_sum - (PW+1)'(NUM_REQ))
                                                        : w_sum[PW-1:0];
  end

  // Scan from the far end so the candidate closest to the pointer overwrites last.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[w_rot_idx[k]]) begin
        o_idx   = w_rot_idx[k];
        o_valid = 1'b1;
      end
    end
    o_grant = o_valid ? (NUM_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/hp_arbiter.sv
// Player HP owner: round-robin req/ack access, invulnerability window, latched death.
// Optional HP regeneration in ACTIVE when HP_ARBITER_REGEN_EN is defined.
module hp_arbiter
  import game_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HP_W         = GAME_HP_W,
  parameter int HP_MAX       = GAME_HP_MAX,
  parameter int TICK_DIV     = GAME_TICK_DIV,
  parameter int INVULN_TICKS = GAME_INVULN_TICKS,
  parameter int PLAY_STATE   = GAME_PLAY_STATE
`ifdef HP_ARBITER_REGEN_EN
  ,
  parameter int REGEN_TICKS  = 120
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              state,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_heal,
  input  logic [NUM_REQ*HP_W-1:0] req_amt,
  output logic [NUM_REQ-1:0]      ack,
  output logic [HP_W-1:0]         hp,
  output logic                    invuln,
  output logic                    dead,
  output logic                    hit_pulse
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(INVULN_TICKS + 1);
  localparam logic [HP_W:0] HP_MAX_X = (HP_W+1)'(HP_MAX);

  hp_fsm_e            r_fsm, w_fsm_next;
  logic [HP_W-1:0]    r_hp, w_hp_next;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_hit;
  logic [PW-1:0]      r_ptr;
  logic [TW-1:0]      r_tick_cnt;
  logic [IW-1:0]      r_inv_cnt, w_inv_cnt_next;

  logic               w_tick, w_play, w_arb_en, w_valid, w_heal, w_hit;
  logic [NUM_REQ-1:0] w_req_eff, w_grant;
  logic [PW-1:0]      w_win;
  logic [HP_W-1:0]    w_amt, w_heal_val, w_dmg_val;
  logic [HP_W:0]      w_sum;

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_play = (state == 4'(PLAY_STATE));

  // IDLE may grant on the cycle play starts, since it becomes ACTIVE at that edge.
  // Requesters being acked this cycle are masked so a held req is not granted twice.
  assign w_arb_en  = w_play && (r_fsm != ST_DEAD);
  assign w_req_eff = w_arb_en ? (req & ~r_ack) : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (w_req_eff),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win),
    .o_valid (w_valid)
  );

  assign w_amt      = req_amt[int'(w_win)*HP_W +: HP_W];
  assign w_heal     = req_heal[w_win];
  assign w_sum      = {1'b0, r_hp} + {1'b0, w_amt};
  assign w_heal_val = (w_sum > HP_MAX_X) ? HP_W'(HP_MAX) : w_sum[HP_W-1:0];
  assign w_dmg_val  = (r_hp >= w_amt) ? (r_hp - w_amt) : '0;
  assign w_hit      = w_valid && !w_heal && (w_amt != '0) && (r_fsm != ST_INVULN);

`ifdef HP_ARBITER_REGEN_EN
  localparam int RW = (REGEN_TICKS > 1) ? $clog2(REGEN_TICKS) : 1;

  logic [RW-1:0] r_regen_cnt;
  logic          r_regen_pend;
  logic          w_regen_step;

  // A pending step waits for a grant-free cycle so the grant is never lost.
  assign w_regen_step = r_regen_pend && (r_fsm == ST_ACTIVE) && !w_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regen_cnt  <= '0;
      r_regen_pend <= 1'b0;
    end else if (w_hit || (r_fsm != ST_ACTIVE)) begin
      r_regen_cnt  <= '0;
      r_regen_pend <= 1'b0;
    end else begin
      if (w_regen_step) r_regen_pend <= 1'b0;
      if (w_tick) begin
        if (r_regen_cnt == RW'(REGEN_TICKS - 1)) begin
          r_regen_cnt  <= '0;
          r_regen_pend <= 1'b1;
        end else begin
          r_regen_cnt <= r_regen_cnt + 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    w_hp_next = r_hp;
    if (w_valid && w_heal) begin
      w_hp_next = w_heal_val;
    end else if (w_hit) begin
      w_hp_next = w_dmg_val;
    end
`ifdef HP_ARBITER_REGEN_EN
    else if (w_regen_step && (r_hp != HP_W'(HP_MAX))) begin
      w_hp_next = r_hp + 1'b1;
    end
`endif
  end

  always_comb begin
    w_fsm_next     = r_fsm;
    w_inv_cnt_next = r_inv_cnt;
    case (r_fsm)
      ST_DEAD: w_fsm_next = ST_DEAD;
      default: begin
        if (w_hit && (w_dmg_val == '0)) begin
          w_fsm_next = ST_DEAD;
        end else if (!w_play) begin
          w_fsm_next = ST_IDLE;
        end else if (w_hit) begin
          w_fsm_next     = ST_INVULN;
          w_inv_cnt_next = IW'(INVULN_TICKS);
        end else if (r_fsm == ST_IDLE) begin
          w_fsm_next = ST_ACTIVE;
        end else if ((r_fsm == ST_INVULN) && w_tick) begin
          if (r_inv_cnt <= IW'(1)) w_fsm_next = ST_ACTIVE;
          else                     w_inv_cnt_next = r_inv_cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm      <= ST_IDLE;
      r_hp       <= HP_W'(HP_MAX);
      r_ack      <= '0;
      r_hit      <= 1'b0;
      r_ptr      <= '0;
      r_tick_cnt <= '0;
      r_inv_cnt  <= '0;
    end else begin
      r_fsm      <= w_fsm_next;
      r_hp       <= w_hp_next;
      r_ack      <= w_grant;
      r_hit      <= w_hit;
      r_inv_cnt  <= w_inv_cnt_next;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_valid) r_ptr <= (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    end
  end

  assign ack       = r_ack;
  assign hp        = r_hp;
  assign hit_pulse = r_hit;
  assign invuln    = (r_fsm == ST_INVULN);
  assign dead      = (r_fsm == ST_DEAD);

endmodule
